// File: rtl/half_add.sv
// ----------------------------------------------------------------------------
// half_add
//
// A 1-bit half adder with three parts:
//   - a purely combinational result (sum_o / carry_o),
//   - a registered copy of the result for qualified operands, with a
//     registered valid flag,
//   - two saturating statistics counters: accepted operations, and accepted
//     operations that produced a carry.
//
// Parameters
//   CNT_W        width of both statistics counters (minimum 2)
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous, active-low reset of all registered state
//   a_i, b_i     addends
//   valid_i      qualifies a_i/b_i for the registered path and the counters
//   clr_i        synchronous clear of both counters (beats an increment)
//   sum_o        a_i ^ b_i, combinational
//   carry_o      a_i & b_i, combinational
//   sum_q_o      sum of the last accepted operands
//   carry_q_o    carry of the last accepted operands
//   valid_q_o    valid_i delayed by one cycle
//   op_cnt_o     number of accepted operations (saturating)
//   carry_cnt_o  number of accepted operations with a carry (saturating)
// ----------------------------------------------------------------------------
module half_add #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             valid_i,
  input  logic             clr_i,
  output logic             sum_o,
  output logic             carry_o,
  output logic             sum_q_o,
  output logic             carry_q_o,
  output logic             valid_q_o,
  output logic [CNT_W-1:0] op_cnt_o,
  output logic [CNT_W-1:0] carry_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Combinational half adder. Plain operators are used so that X/Z on the
  // inputs propagate to the outputs instead of being masked.
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

  // --------------------------------------------------------------------------
  // Registered result path
  // --------------------------------------------------------------------------
  logic sum_q,   sum_d;
  logic carry_q, carry_d;
  logic valid_q, valid_d;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_i;
    if (valid_i) begin
      sum_d   = a_i ^ b_i;
      carry_d = a_i & b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum_q_o   = sum_q;
  assign carry_q_o = carry_q;
  assign valid_q_o = valid_q;

  // --------------------------------------------------------------------------
  // Statistics counters
  //   index 0: accepted operations
  //   index 1: accepted operations with a = b = 1
  // Both counters share identical clear/saturate behaviour and differ only in
  // their increment condition.
  // --------------------------------------------------------------------------
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_vec;

  assign cnt_inc[0] = valid_i;
  assign cnt_inc[1] = valid_i & a_i & b_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Clear wins over increment; at the maximum value the counter holds.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (cnt_inc[gi] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_vec[gi] = cnt_q;
    end
  endgenerate

  assign op_cnt_o    = cnt_vec[0];
  assign carry_cnt_o = cnt_vec[1];

endmodule

// File: tb/tb_half_add.sv
// ----------------------------------------------------------------------------
// tb_half_add
//
// Directed bench for half_add. Two instances share the same stimulus: one with
// the default 16-bit counters and one with 2-bit counters for saturation.
// ----------------------------------------------------------------------------
module tb_half_add;

  logic clk;
  logic rst_ni;
  logic a_i, b_i, valid_i, clr_i;

  logic        sum_o, carry_o, sum_q_o, carry_q_o, valid_q_o;
  logic [15:0] op_cnt_o, carry_cnt_o;

  logic        s_sum_o, s_carry_o, s_sum_q_o, s_carry_q_o, s_valid_q_o;
  logic [1:0]  s_op_cnt_o, s_carry_cnt_o;

  int checks = 0;
  int errors = 0;

  half_add #(.CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .a_i        (a_i),
    .b_i        (b_i),
    .valid_i    (valid_i),
    .clr_i      (clr_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .sum_q_o    (sum_q_o),
    .carry_q_o  (carry_q_o),
    .valid_q_o  (valid_q_o),
    .op_cnt_o   (op_cnt_o),
    .carry_cnt_o(carry_cnt_o)
  );

  half_add #(.CNT_W(2)) dut_sat (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .a_i        (a_i),
    .b_i        (b_i),
    .valid_i    (valid_i),
    .clr_i      (clr_i),
    .sum_o      (s_sum_o),
    .carry_o    (s_carry_o),
    .sum_q_o    (s_sum_q_o),
    .carry_q_o  (s_carry_q_o),
    .valid_q_o  (s_valid_q_o),
    .op_cnt_o   (s_op_cnt_o),
    .carry_cnt_o(s_carry_cnt_o)
  );

  // Period 20 ns: first rising edge at 10 ns leaves room for the
  // combinational sweep and reset checks before any clock edge.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Combinational sweep point: a mismatch here stops the run.
  task automatic sweep(input logic a, input logic b, input logic es, input logic ec);
    a_i = a;
    b_i = b;
    #1;
    checks++;
    if ({sum_o, carry_o} !== {es, ec}) begin
      errors++;
      $error("FAIL comb_%0b%0b observed=%0b%0b expected=%0b%0b", a, b, sum_o, carry_o, es, ec);
      $fatal(1, "combinational sweep mismatch");
    end
    $display("check comb_%0b%0b      observed=%0b%0b expected=%0b%0b", a, b, sum_o, carry_o, es, ec);
  endtask

  // Apply inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic a, input logic b, input logic v, input logic c);
    a_i     = a;
    b_i     = b;
    valid_i = v;
    clr_i   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic s, input logic c, input logic v);
    chk({tag, "_sum_q"},   {31'd0, sum_q_o},   {31'd0, s});
    chk({tag, "_carry_q"}, {31'd0, carry_q_o}, {31'd0, c});
    chk({tag, "_valid_q"}, {31'd0, valid_q_o}, {31'd0, v});
  endtask

  task automatic chk_cnts(input string tag, input int op, input int cy, input int sop, input int scy);
    chk({tag, "_op"},     {16'd0, op_cnt_o},         op);
    chk({tag, "_cy"},     {16'd0, carry_cnt_o},      cy);
    chk({tag, "_sat_op"}, {30'd0, s_op_cnt_o},       sop);
    chk({tag, "_sat_cy"}, {30'd0, s_carry_cnt_o},    scy);
  endtask

  logic [3:0] exp_sum_tab;
  logic [3:0] exp_cy_tab;

  initial begin
    exp_sum_tab = 4'b0110;  // indexed by {a,b}: 00->0 01->1 10->1 11->0
    exp_cy_tab  = 4'b1000;  // only 11 carries
    rst_ni  = 1'b1;
    a_i     = 1'b0;
    b_i     = 1'b0;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    #1;
    rst_ni = 1'b0;

    // Combinational sweep, no clock edges yet.
    sweep(1'b0, 1'b0, 1'b0, 1'b0);
    sweep(1'b0, 1'b1, 1'b1, 1'b0);
    sweep(1'b1, 1'b0, 1'b1, 1'b0);
    sweep(1'b1, 1'b1, 1'b0, 1'b1);

    // Reset state, still before the first edge.
    chk_regs("rst", 1'b0, 1'b0, 1'b0);
    chk_cnts("rst", 0, 0, 0, 0);
    #1;
    rst_ni = 1'b1;

    // Registered path: one accepted 11, then an idle cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_regs("acc11", 1'b0, 1'b1, 1'b1);
    chk_cnts("acc11", 1, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_regs("idle", 1'b0, 1'b1, 1'b0);
    chk_cnts("idle", 1, 1, 1, 1);

    // Clear without an operation.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnts("clr", 0, 0, 0, 0);

    // All four combinations twice.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ab;
      ab = i[1:0];
      step(ab[1], ab[0], 1'b1, 1'b0);
      chk_regs($sformatf("seq%0d", i), exp_sum_tab[ab], exp_cy_tab[ab], 1'b1);
    end
    chk_cnts("seq", 8, 2, 3, 2);

    // Saturation: five accepted 11 operations after a clear.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnts("clr2", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_cnts("sat", 5, 5, 3, 3);

    // Load 01 so the next result visibly changes, then clear with an 11.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_regs("acc01", 1'b1, 1'b0, 1'b1);
    chk_cnts("acc01", 6, 5, 3, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_regs("clr11", 1'b0, 1'b1, 1'b1);
    chk_cnts("clr11", 0, 0, 0, 0);

    // Reset between edges.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_regs("pre_rst", 1'b1, 1'b0, 1'b1);
    chk_cnts("pre_rst", 1, 0, 1, 0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_regs("mid_rst", 1'b0, 1'b0, 1'b0);
    chk_cnts("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_sum",   {31'd0, sum_o},   32'd1);
    chk("mid_rst_carry", {31'd0, carry_o}, 32'd0);
    a_i = 1'b1;
    b_i = 1'b1;
    #1;
    chk("mid_rst_sum11",   {31'd0, sum_o},   32'd0);
    chk("mid_rst_carry11", {31'd0, carry_o}, 32'd1);
    #1;
    rst_ni = 1'b1;

    // First accepted edge after reset behaves normally.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_regs("post_rst", 1'b0, 1'b1, 1'b1);
    chk_cnts("post_rst", 1, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_add.md
HALF_ADD -- requirements
Module: half_add

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters (minimum 2).
REQ-002 clk_i  input  1  single clock; all sequential logic on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 a_i  input  1  addend A.
REQ-005 b_i  input  1  addend B.
REQ-006 valid_i  input  1  qualifies a_i/b_i for the registered path and the counters.
REQ-007 clr_i  input  1  synchronous clear of both counters.
REQ-008 sum_o  output  1  combinational sum, a_i XOR b_i.
REQ-009 carry_o  output  1  combinational carry, a_i AND b_i.
REQ-010 sum_q_o  output  1  registered sum of the last accepted operands.
REQ-011 carry_q_o  output  1  registered carry of the last accepted operands.
REQ-012 valid_q_o  output  1  registered result valid.
REQ-013 op_cnt_o  output  CNT_W  count of accepted operations.
REQ-014 carry_cnt_o  output  CNT_W  count of accepted operations that produced carry = 1.

Function
REQ-015 sum_o SHALL equal a_i ^ b_i and carry_o SHALL equal a_i & b_i at all times, purely combinationally, with no dependency on clk_i, rst_ni or valid_i.
REQ-016 Truth table for sum_o/carry_o SHALL be: 00->0/0, 01->1/0, 10->1/0, 11->0/1.
REQ-017 A cycle with valid_i = 1 at the rising edge is an accepted operation.
REQ-018 On an accepted operation, sum_q_o/carry_q_o SHALL load a_i^b_i / a_i&b_i; latency is exactly 1 cycle.
REQ-019 valid_q_o SHALL equal valid_i registered by one cycle.
REQ-020 With valid_i = 0, sum_q_o/carry_q_o SHALL hold their previous values.
REQ-021 op_cnt_o SHALL increment by 1 on every accepted operation.
REQ-022 carry_cnt_o SHALL increment by 1 on every accepted operation with a_i = b_i = 1.
REQ-023 Both counters SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-024 clr_i = 1 SHALL set both counters to 0 on the next edge and SHALL take priority over a simultaneous increment; the registered result path is unaffected by clr_i.
REQ-025 Counter outputs SHALL reflect their registered values; the counters have no combinational bypass.
REQ-026 X/Z on a_i or b_i SHALL NOT be masked; the combinational outputs propagate them per standard operator semantics.

Reset
REQ-027 While rst_ni = 0, sum_q_o, carry_q_o, valid_q_o, op_cnt_o and carry_cnt_o SHALL be 0, asserted immediately without waiting for a clock edge.
REQ-028 Reset SHALL NOT affect sum_o/carry_o, which keep tracking a_i/b_i.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight result; the first edge after deassertion with valid_i = 1 behaves as a normal accepted operation.

Verification
REQ-030 Combinational sweep, no clock edges: (a,b) = 00,01,10,11, each checked after a 1 ns settle -> sum/carry = 0/0, 1/0, 1/0, 0/1, compared with the 4-state not-equal check; any mismatch is fatal.
REQ-031 Registered path: valid_i = 1 with a = b = 1 for one cycle -> next cycle sum_q_o = 0, carry_q_o = 1, valid_q_o = 1; following idle cycle -> valid_q_o = 0 and sum_q_o/carry_q_o held.
REQ-032 Counters: accept the 4 input combinations twice each -> op_cnt_o = 8, carry_cnt_o = 2.
REQ-033 Saturation with CNT_W = 2: 5 accepted 11 operations -> both counters = 3.
REQ-034 clr_i asserted together with an accepted 11 operation -> both counters = 0 next cycle; sum_q_o = 0, carry_q_o = 1.
REQ-035 rst_ni pulled low between clock edges -> all registered outputs are 0 before the next edge, and sum_o/carry_o still match the inputs.
